// File: rtl/noc_flit_sender_pkg.sv
// Shared flit layout for the flit sender: data width, {head, tail, data} flit struct
// and a small builder helper.
package noc_flit_sender_pkg;

  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;

  localparam int FLIT_WIDTH = $bits(flit_t);

  function automatic flit_t make_flit(input logic head, input logic tail,
                                      input logic [DATA_WIDTH-1:0] data);
    flit_t f;
    f.head = head;
    f.tail = tail;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/noc_flit_sender.sv
// Packet-to-flit sender: one head flit from a latched header, then N payload flits passed
// straight through, tail on the last. Optional length checking with NOC_FLIT_SENDER_LENGTH_CHECK_EN.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both high at the
// rising clock edge; valid never depends on ready, and a stalled head flit is held stable.
module noc_flit_sender
  import noc_flit_sender_pkg::*;
#(
  parameter  int MAX_LENGTH = 16,
  localparam int LEN_W      = $clog2(MAX_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_header_valid,
  output logic                  o_header_ready,
  input  logic [DATA_WIDTH-1:0] i_header,
  input  logic [LEN_W-1:0]      i_length,
  input  logic                  i_payload_valid,
  output logic                  o_payload_ready,
  input  logic [DATA_WIDTH-1:0] i_payload,
  output logic                  flit_out_valid,
  input  logic                  flit_out_ready,
  output logic [FLIT_WIDTH-1:0] flit_out_flit,
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
  input  logic                  i_payload_last,
  output logic                  o_length_error,
`endif
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEAD    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  flit_t                 flit;
  logic                  hdr_fire, pay_fire;

  // cnt_q holds the packet length in HEAD and the remaining beats in PAYLOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hdr_d           = hdr_q;
    o_header_ready  = 1'b0;
    o_payload_ready = 1'b0;
    flit_out_valid  = 1'b0;
    flit            = '0;
    hdr_fire        = 1'b0;
    pay_fire        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_header_ready = 1'b1;
        if (i_header_valid) begin
          hdr_fire = 1'b1;
          hdr_d    = i_header;
          cnt_d    = (i_length > MAX_LEN) ? MAX_LEN : i_length;
          state_d  = S_HEAD;
        end
      end
      S_HEAD: begin
        flit_out_valid = 1'b1;
        flit           = make_flit(1'b1, cnt_q == '0, hdr_q);
        if (flit_out_ready) begin
          state_d = (cnt_q == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        flit_out_valid  = i_payload_valid;
        o_payload_ready = flit_out_ready;
        flit            = make_flit(1'b0, cnt_q == ONE, i_payload);
        if (i_payload_valid && flit_out_ready) begin
          pay_fire = 1'b1;
          cnt_d    = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake seen in the same cycle; the packet ends without a tail.
    if (i_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign flit_out_flit = flit;
  assign o_busy        = (state_q != S_IDLE);
  assign o_state       = state_q;

`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (hdr_fire && (i_length > MAX_LEN)) begin
      err_d = 1'b1;
    end
    if (pay_fire && (i_payload_last != (cnt_q == ONE))) begin
      err_d = 1'b1;
    end
    if (i_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_length_error = err_q;
`endif

endmodule

// File: tb/tb_noc_flit_sender.sv
// Bench for noc_flit_sender: directed packets plus randomized traffic checked against a
// packet-level model that predicts the flit list for every request.
module tb_noc_flit_sender;
  import noc_flit_sender_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic                  clk;
  logic                  rst_n;
  logic                  i_clear;
  logic                  i_header_valid;
  logic                  o_header_ready;
  logic [DATA_WIDTH-1:0] i_header;
  logic [LEN_W-1:0]      i_length;
  logic                  i_payload_valid;
  logic                  o_payload_ready;
  logic [DATA_WIDTH-1:0] i_payload;
  logic                  flit_out_valid;
  logic                  flit_out_ready;
  logic [FLIT_WIDTH-1:0] flit_out_flit;
  logic                  o_busy;
  logic [1:0]            o_state;
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
  logic                  i_payload_last;
  logic                  o_length_error;
  logic                  err_m;
`endif

  logic [FLIT_WIDTH-1:0] exp_q[$];
  int                    n_tests;
  int                    n_fail;
  int                    busy_cnt;
  bit                    rand_ready;
  logic                  prev_stall;
  logic [FLIT_WIDTH-1:0] prev_flit;

  noc_flit_sender #(.MAX_LENGTH(MAX_LEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (i_clear),
    .i_header_valid (i_header_valid),
    .o_header_ready (o_header_ready),
    .i_header       (i_header),
    .i_length       (i_length),
    .i_payload_valid(i_payload_valid),
    .o_payload_ready(o_payload_ready),
    .i_payload      (i_payload),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .flit_out_flit  (flit_out_flit),
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
    .i_payload_last (i_payload_last),
    .o_length_error (o_length_error),
`endif
    .o_busy         (o_busy),
    .o_state        (o_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) flit_out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: every transferred flit must be the next predicted flit; stalled flits hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy) busy_cnt++;
      if (prev_stall) begin
        chk("hold_valid", flit_out_valid, 1);
        chk("hold_flit", flit_out_flit, prev_flit);
      end
      if (flit_out_valid && flit_out_ready) begin
        chk("flit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("flit", flit_out_flit, exp_q.pop_front());
      end
      prev_stall = flit_out_valid && !flit_out_ready && !i_clear;
      prev_flit  = flit_out_flit;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One packet request. stall: cycles of ready low during the head flit; clear_at: abort
  // after this many payload beats (>=1, or -1 for none); bad_last: beat with wrong last flag.
  task automatic send_packet(input logic [DATA_WIDTH-1:0] hdr, input int len, input int stall,
                             input int clear_at, input int bad_last, input bit bubbles);
    int n, stop, t;
    bit got;
    logic [DATA_WIDTH-1:0] pay[$];
    n    = (len > MAX_LEN) ? MAX_LEN : len;
    stop = (clear_at >= 0 && clear_at < n) ? clear_at : n;
    for (int i = 0; i < n; i++) pay.push_back($urandom);
    exp_q.push_back({1'b1, n == 0, hdr});
    for (int i = 0; i < stop; i++) exp_q.push_back({1'b0, i == n - 1, pay[i]});
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
    if (len > MAX_LEN) err_m = 1'b1;
    if (bad_last >= 0 && bad_last < stop) err_m = 1'b1;
`endif
    i_header       = hdr;
    i_length       = len[LEN_W-1:0];
    i_header_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (o_header_ready) break;
      t++;
      if (t > 300) begin
        chk("hdr_wait", o_header_ready, 1);
        i_header_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    i_header_valid = 1'b0;
    if (stall > 0) flit_out_ready = 1'b0;
    if (stop > 0) begin
      i_payload_valid = 1'b1;
      i_payload       = pay[0];
    end
    @(negedge clk);
    chk("head_latency", flit_out_valid, 1);
    chk("head_pay_rdy", o_payload_ready, 0);
    chk("busy_after_hdr", o_busy, 1);
    for (int s = 1; s < stall; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_head", flit_out_flit, {1'b1, n == 0, hdr});
      chk("stall_pay_rdy", o_payload_ready, 0);
    end
    @(posedge clk); #1;
    if (stall > 0) flit_out_ready = 1'b1;
    for (int i = 0; i < stop; i++) begin
      if (i > 0) begin
        while (bubbles && $urandom_range(0, 3) == 0) begin
          i_payload_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      i_payload_valid = 1'b1;
      i_payload       = pay[i];
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
      i_payload_last  = (i == bad_last) ? (i != n - 1) : (i == n - 1);
`endif
      t   = 0;
      got = 1'b0;
      while (!got) begin
        @(negedge clk);
        got = o_payload_ready;
        @(posedge clk); #1;
        t++;
        if (!got && t > 300) begin
          chk("pay_wait", o_payload_ready, 1);
          i_payload_valid = 1'b0;
          return;
        end
      end
    end
    i_payload_valid = 1'b0;
    if (stop < n) begin
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      @(negedge clk);
      chk("clr_valid", flit_out_valid, 0);
      chk("clr_busy", o_busy, 0);
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
      err_m = 1'b0;
`endif
    end else begin
      t = 0;
      forever begin
        @(negedge clk);
        if (!o_busy) break;
        t++;
        if (t > 300) begin
          chk("idle_wait", o_busy, 0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    chk("pkt_drained", exp_q.size(), 0);
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
    chk("len_err", o_length_error, err_m);
`endif
  endtask

  initial begin
    n_tests = 0; n_fail = 0; busy_cnt = 0;
    rand_ready = 1'b0; prev_stall = 1'b0; prev_flit = '0;
    rst_n = 1'b0; i_clear = 1'b0; i_header_valid = 1'b0; i_header = '0; i_length = '0;
    i_payload_valid = 1'b0; i_payload = '0; flit_out_ready = 1'b1;
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
    i_payload_last = 1'b0; err_m = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", flit_out_valid, 0);
    chk("rst_pay_rdy", o_payload_ready, 0);
    chk("rst_hdr_rdy", o_header_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_state", o_state, 0);
`ifdef NOC_FLIT_SENDER_LENGTH_CHECK_EN
    chk("rst_len_err", o_length_error, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Head-only packet, then a short packet with its busy window measured
    send_packet(32'hA5, 0, 0, -1, -1, 1'b0);
    busy_cnt = 0;
    send_packet(32'h11, 3, 0, -1, -1, 1'b0);
    chk("busy_cycles", busy_cnt, 4);
    // Head flit held under backpressure
    send_packet(32'h22, 2, 5, -1, -1, 1'b0);
    // Abort with two beats remaining, then a clean packet
    send_packet(32'h33, 4, 0, 2, -1, 1'b0);
    send_packet(32'h44, 1, 0, -1, -1, 1'b0);
    // Oversized length is clamped to MAX_LEN
    send_packet(32'h55, 20, 0, -1, -1, 1'b0);
    // Wrong last flag on the 2nd beat; three flits still go out
    send_packet(32'h66, 3, 0, -1, 1, 1'b0);
    // Clear the sticky error before random traffic
    send_packet(32'h77, 3, 0, 1, -1, 1'b0);

    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_packet($urandom, $urandom_range(0, 20), 0, -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, 1'b1);
    end
    rand_ready = 1'b0;
    flit_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
